// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, lamp codes and sizing helper for the multi-approach light
package traffic_pkg;
  typedef enum logic [1:0] {ALL_RED, GREEN, YELLOW, FLASH} state_t;
  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/tlc_phase_timer.sv
// tlc_phase_timer: tick-gated phase counter with clear, hold and end-of-duration strobe
module tlc_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_en,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] dur,
  output logic         done,
  output logic [W-1:0] count
);
  assign done = tick_en && !hold && count == dur - 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else count <= (clr || done) ? '0 : (tick_en && !hold) ? count + 1'b1 : count;
endmodule

// File: rtl/traffic_light_multi.sv
// traffic_light_multi: N-approach signal controller with ped calls, preemption and flashing-red mode
module traffic_light_multi
  import traffic_pkg::*;
#(
  parameter int N_DIR     = 2,
  parameter int GREEN_T   = 8,
  parameter int MIN_GREEN = 3,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int FLASH_T   = 4,
  localparam int DIR_W    = max2(1, $clog2(N_DIR)),
  localparam int TMR_W    = $clog2(max2(max2(GREEN_T, YELLOW_T), max2(ALLRED_T, FLASH_T)) + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_en,
  input  logic [N_DIR-1:0]   ped_req,
  input  logic               preempt_req,
  input  logic [DIR_W-1:0]   preempt_dir,
  input  logic               flash_en,
  output logic [3*N_DIR-1:0] lights,
  output logic [N_DIR-1:0]   walk,
  output logic [DIR_W-1:0]   phase,
  output logic               preempt_act
);
  localparam logic [DIR_W:0]   NDIR  = (DIR_W+1)'(N_DIR);
  localparam logic [DIR_W-1:0] LAST  = DIR_W'(N_DIR - 1);
  localparam logic [TMR_W-1:0] D_GRN = TMR_W'(GREEN_T);
  localparam logic [TMR_W-1:0] D_YEL = TMR_W'(YELLOW_T);
  localparam logic [TMR_W-1:0] D_RED = TMR_W'(ALLRED_T);
  localparam logic [TMR_W-1:0] D_FLS = TMR_W'(FLASH_T);
  localparam logic [TMR_W-1:0] D_MIN = TMR_W'(MIN_GREEN - 1);
  state_t           state, ns;
  logic [DIR_W-1:0] nphase, nxt_dir;
  logic [N_DIR-1:0] ped_pend, ph_oh, nph_oh;
  logic             first, served, flash_off, act;
  logic             pv, hold, done, enter_g;
  logic [TMR_W-1:0] count, dur;
  assign pv      = preempt_req && ({1'b0, preempt_dir} < NDIR);
  assign hold    = state == GREEN && pv && preempt_dir == phase;
  assign dur     = state == GREEN ? D_GRN : state == YELLOW ? D_YEL : state == FLASH ? D_FLS : D_RED;
  assign ph_oh   = {{(N_DIR-1){1'b0}}, 1'b1} << phase;
  assign nph_oh  = {{(N_DIR-1){1'b0}}, 1'b1} << nphase;
  assign nxt_dir = (first || phase == LAST) ? '0 : phase + 1'b1;
  assign enter_g = ns == GREEN && state != GREEN;
  tlc_phase_timer #(.W(TMR_W)) u_tmr (
    .clk(clk), .reset(reset), .tick_en(tick_en), .clr(ns != state),
    .hold(hold), .dur(dur), .done(done), .count(count)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= ALL_RED;
      phase     <= '0;
      ped_pend  <= '0;
      first     <= 1'b1;
      served    <= 1'b0;
      flash_off <= 1'b0;
      act       <= 1'b0;
    end else begin
      state     <= ns;
      phase     <= nphase;
      ped_pend  <= (ped_pend | ped_req) & ~(enter_g ? nph_oh : '0);
      first     <= first && !(state == ALL_RED && ns != ALL_RED);
      served    <= ns == GREEN && (enter_g ? |((ped_pend | ped_req) & nph_oh) : served);
      flash_off <= ns == FLASH && (state == FLASH && done ? !flash_off : flash_off);
      act       <= ns == GREEN && pv && preempt_dir == nphase;
    end
  always_comb begin
    ns     = state;
    nphase = phase;
    case (state)
      ALL_RED: if (done) begin
        ns     = flash_en ? FLASH : GREEN;
        nphase = flash_en ? phase : pv ? preempt_dir : nxt_dir;
      end
      GREEN: if (done || (tick_en && !hold && ((|(ped_pend & ~ph_oh) && count >= D_MIN) || pv)))
        ns = YELLOW;
      YELLOW: if (done) ns = ALL_RED;
      FLASH: if (tick_en && !flash_en) begin
        ns     = ALL_RED;
        nphase = LAST;
      end
      default: ns = ALL_RED;
    endcase
  end
  always_comb begin
    lights = '0;
    for (int i = 0; i < N_DIR; i++)
      lights[3*i+:3] = state == FLASH ? (flash_off ? LT_OFF : LT_RED) :
                       phase != DIR_W'(i) ? LT_RED :
                       state == GREEN ? LT_GRN : state == YELLOW ? LT_YEL : LT_RED;
    walk        = served ? ph_oh : '0;
    preempt_act = act;
  end
endmodule

// File: tb/tb_traffic_light_multi.sv
// tb_traffic_light_multi: table-driven directed checks of the 2-approach controller
module tb_traffic_light_multi;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_en = 1'b1;
  logic [1:0] ped_req = '0;
  logic       preempt_req = 1'b0;
  logic [0:0] preempt_dir = '0;
  logic       flash_en = 1'b0;
  logic [5:0] lights;
  logic [1:0] walk;
  logic [0:0] phase;
  logic       preempt_act;
  int errs = 0;
  int checks = 0;
  typedef struct {
    logic [1:0] ped;
    logic       pre;
    logic       pdir;
    logic       fl;
    logic       tk;
    logic [5:0] lt;
    logic [1:0] wk;
    logic       ph;
    logic       act;
  } vec_t;
  vec_t q[$];
  traffic_light_multi #(
    .N_DIR(2), .GREEN_T(8), .MIN_GREEN(3), .YELLOW_T(2), .ALLRED_T(1), .FLASH_T(4)
  ) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .ped_req(ped_req),
    .preempt_req(preempt_req), .preempt_dir(preempt_dir), .flash_en(flash_en),
    .lights(lights), .walk(walk), .phase(phase), .preempt_act(preempt_act)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int row, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s row %0d: got lights/walk/phase/act=%b expected %b", name, row, got, exp);
    end
  endtask
  task automatic add(input int n, input logic [1:0] ped, input logic pre, input logic pdir,
                     input logic fl, input logic tk, input logic [5:0] lt, input logic [1:0] wk,
                     input logic ph, input logic act);
    vec_t v;
    v = '{ped, pre, pdir, fl, tk, lt, wk, ph, act};
    repeat (n) q.push_back(v);
  endtask
  task automatic idle_inputs();
    ped_req = '0; preempt_req = 1'b0; preempt_dir = '0; flash_en = 1'b0; tick_en = 1'b1;
  endtask
  task automatic run(input string name);
    foreach (q[i]) begin
      ped_req = q[i].ped; preempt_req = q[i].pre; preempt_dir = q[i].pdir;
      flash_en = q[i].fl; tick_en = q[i].tk;
      @(posedge clk);
      #1;
      chk(name, i, {lights, walk, phase, preempt_act}, {q[i].lt, q[i].wk, q[i].ph, q[i].act});
    end
    q.delete();
    idle_inputs();
  endtask
  task automatic do_reset(input string name);
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk(name, -1, {lights, walk, phase, preempt_act}, {6'b100_100, 2'b00, 1'b0, 1'b0});
  endtask
  initial begin
    // reset release: full cycle of dir0 then dir1 green
    do_reset("reset_seq");
    add(8, 0, 0, 0, 0, 1, 6'b100_001, 0, 0, 0);
    add(2, 0, 0, 0, 0, 1, 6'b100_010, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 6'b100_100, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 6'b001_100, 0, 1, 0);
    run("reset_seq");
    // ped call for dir1 truncates dir0 green at minimum, served with walk
    do_reset("ped");
    add(2, 0, 0, 0, 0, 1, 6'b100_001, 0, 0, 0);
    add(1, 2'b10, 0, 0, 0, 1, 6'b100_001, 0, 0, 0);
    add(2, 0, 0, 0, 0, 1, 6'b100_010, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 6'b100_100, 0, 0, 0);
    add(8, 0, 0, 0, 0, 1, 6'b001_100, 2'b10, 1, 0);
    add(2, 0, 0, 0, 0, 1, 6'b010_100, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 6'b100_100, 0, 1, 0);
    add(8, 0, 0, 0, 0, 1, 6'b100_001, 0, 0, 0);
    add(2, 0, 0, 0, 0, 1, 6'b100_010, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 6'b100_100, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 6'b001_100, 0, 1, 0);
    run("ped");
    // preemption to dir1: immediate yellow, held green, resumes for 8 ticks
    do_reset("preempt");
    add(1, 0, 0, 0, 0, 1, 6'b100_001, 0, 0, 0);
    add(2, 0, 1, 1, 0, 1, 6'b100_010, 0, 0, 0);
    add(1, 0, 1, 1, 0, 1, 6'b100_100, 0, 0, 0);
    add(20, 0, 1, 1, 0, 1, 6'b001_100, 0, 1, 1);
    add(7, 0, 0, 0, 0, 1, 6'b001_100, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 6'b010_100, 0, 1, 0);
    run("preempt");
    // flash mode after normal clearance, exit returns to dir0
    do_reset("flash");
    add(2, 0, 0, 0, 0, 1, 6'b100_001, 0, 0, 0);
    add(6, 0, 0, 0, 1, 1, 6'b100_001, 0, 0, 0);
    add(2, 0, 0, 0, 1, 1, 6'b100_010, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 6'b100_100, 0, 0, 0);
    add(4, 0, 0, 0, 1, 1, 6'b100_100, 0, 0, 0);
    add(4, 0, 0, 0, 1, 1, 6'b000_000, 0, 0, 0);
    add(4, 0, 0, 0, 1, 1, 6'b100_100, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 6'b100_100, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 6'b100_001, 0, 0, 0);
    run("flash");
    // tick every third cycle stretches each state x3
    do_reset("tick3");
    for (int i = 0; i < 36; i++)
      add(1, 0, 0, 0, 0, (i % 3) == 2,
          i < 2 ? 6'b100_100 : i < 26 ? 6'b100_001 : i < 32 ? 6'b100_010 :
          i < 35 ? 6'b100_100 : 6'b001_100, 0, i >= 35, 0);
    run("tick3");
    // async reset mid-yellow drops a pending call
    do_reset("async");
    add(8, 0, 0, 0, 0, 1, 6'b100_001, 0, 0, 0);
    add(1, 2'b10, 0, 0, 0, 1, 6'b100_010, 0, 0, 0);
    run("async");
    #3;
    reset = 1'b0;
    #1;
    chk("async_now", 0, {lights, walk, phase, preempt_act}, {6'b100_100, 2'b00, 1'b0, 1'b0});
    do_reset("async_restart");
    add(8, 0, 0, 0, 0, 1, 6'b100_001, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 6'b100_010, 0, 0, 0);
    run("async_restart");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
